xor_stream_checksum: RTL

//  Parametrised, clocked successor to the 1-bit XOR gate.

---
 rtl/xor_stream_checksum.sv | 121 ++++++++++++
 1 files changed

// File: rtl/xor_stream_checksum.sv
// Frame XOR checksum: folds a stream of words into a running bitwise XOR and
// presents checksum, saturating word count, parity and overflow per frame
// behind a valid/ready handshake.
module xor_stream_checksum #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_xor,
  output logic [LEN_W-1:0] out_count,
  output logic             out_parity,
  output logic             out_overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  // Count increment that sticks at the top value instead of wrapping.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c);
    return (c == CNT_MAX) ? CNT_MAX : c + CNT_ONE;
  endfunction

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   res_xor_q, res_xor_d;
  logic [LEN_W-1:0]   res_cnt_q, res_cnt_d;
  logic               res_ovf_q, res_ovf_d;

  logic               accept;
  logic               complete;
  logic               first_beat;
  logic [WIDTH-1:0]   fold_xor;
  logic [LEN_W-1:0]   fold_cnt;
  logic               fold_ovf;

  // The result slot frees up in the same cycle it is consumed, so a new beat
  // may be taken while out_ready is high even in HOLD. Gated by rst_n so the
  // block advertises nothing while held in reset.
  assign in_ready  = rst_n & ((state_q != S_HOLD) | out_ready);
  assign out_valid = (state_q == S_HOLD);
  assign accept    = in_valid & in_ready;
  assign complete  = out_valid & out_ready;

  // Any beat taken outside ACCUM starts a new frame; internal accumulators
  // are already cleared there, but the first word must not fold into them.
  assign first_beat = (state_q != S_ACCUM);
  assign fold_xor   = first_beat ? in_data : (acc_q ^ in_data);
  assign fold_cnt   = first_beat ? CNT_ONE : sat_inc(cnt_q);
  assign fold_ovf   = ~first_beat & (ovf_q | (cnt_q == CNT_MAX));

  assign out_xor      = res_xor_q;
  assign out_count    = res_cnt_q;
  assign out_overflow = res_ovf_q;
  assign out_parity   = ^res_xor_q;

  // Next-state and datapath update for accepted beats and consumed results.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_xor_d = res_xor_q;
    res_cnt_d = res_cnt_q;
    res_ovf_d = res_ovf_q;
    if (accept) begin
      if (in_last) begin
        res_xor_d = fold_xor;
        res_cnt_d = fold_cnt;
        res_ovf_d = fold_ovf;
        acc_d     = '0;
        cnt_d     = '0;
        ovf_d     = 1'b0;
        state_d   = S_HOLD;
      end else begin
        acc_d     = fold_xor;
        cnt_d     = fold_cnt;
        ovf_d     = fold_ovf;
        state_d   = S_ACCUM;
      end
    end else if (complete) begin
      state_d = S_IDLE;
    end
  end

  // State, accumulator and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_xor_q <= '0;
      res_cnt_q <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_xor_q <= res_xor_d;
      res_cnt_q <= res_cnt_d;
      res_ovf_q <= res_ovf_d;
    end
  end

endmodule
